// File: rtl/sipo_rx4_if.sv
// Bundle of serial-input, control and word-output signals for the sipo_rx4 deserializer.
// The slave modport is the deserializer side; the master modport is whoever feeds bits and takes words.
interface sipo_rx4_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             sin;
    logic             sin_valid;
    logic             msb_first;
    logic             flush;
    logic             clr_ovr;
    logic             dout_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;

    modport slave (
        input  sin, sin_valid, msb_first, flush, clr_ovr, dout_ready,
        output dout, dout_valid, bit_cnt, overrun
    );

    modport master (
        output sin, sin_valid, msb_first, flush, clr_ovr, dout_ready,
        input  dout, dout_valid, bit_cnt, overrun
    );
endinterface

// File: rtl/sipo_rx4.sv
// Serial-in parallel-out receiver: assembles WIDTH accepted bits into a word and
// presents it through a one-deep holding register with a sticky overrun flag.
module sipo_rx4 #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    sipo_rx4_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    // Output handshake: a word is consumed on any rising edge where dout_valid and
    // dout_ready are both 1; dout is held stable while dout_valid=1 and no consume occurs.
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;

    logic             dir_eff;
    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic             consume;

    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        hold_d   = hold_q;
        vld_d    = vld_q;
        ovr_d    = ovr_q;
        complete = 1'b0;
        consume  = vld_q & bus.dout_ready;

        // The direction of a word is taken from msb_first on its first bit only.
        dir_eff  = (cnt_q == '0) ? bus.msb_first : dir_q;
        shifted  = dir_eff ? {sh_q[WIDTH-2:0], bus.sin} : {bus.sin, sh_q[WIDTH-1:1]};

        if (bus.flush) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (bus.sin_valid) begin
            dir_d = dir_eff;
            if (cnt_q == CW'(WIDTH - 1)) begin
                complete = 1'b1;
                sh_d     = '0;
                cnt_d    = '0;
            end else begin
                sh_d  = shifted;
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (bus.clr_ovr) begin
            ovr_d = 1'b0;
        end
        if (consume) begin
            vld_d = 1'b0;
        end
        // A completed word may only land if the holding register is free or being drained.
        if (complete) begin
            if (!vld_q || bus.dout_ready) begin
                hold_d = shifted;
                vld_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            hold_q <= '0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            hold_q <= hold_d;
            vld_q  <= vld_d;
            ovr_q  <= ovr_d;
        end
    end

    assign bus.dout       = hold_q;
    assign bus.dout_valid = vld_q;
    assign bus.bit_cnt    = cnt_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_sipo_rx4.sv
// Testbench for sipo_rx4 (WIDTH=4): directed scenarios plus randomized traffic,
// checked cycle by cycle against a bit-queue reference model and a word scoreboard.
module tb_sipo_rx4;
    localparam int W = 4;

    logic clk;
    logic reset;

    sipo_rx4_if #(.WIDTH(W)) bus ();

    sipo_rx4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model & scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic        m_bits[$];
    logic        m_dir;
    logic [W-1:0] m_hold;
    logic        m_vld;
    logic        m_ovr;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_bits.delete();
        m_dir  = 1'b0;
        m_hold = '0;
        m_vld  = 1'b0;
        m_ovr  = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [W-1:0] assemble(input logic msbf);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (m_bits[i]) begin
                if (msbf) w[W-1-i] = 1'b1;
                else      w[i]     = 1'b1;
            end
        end
        return w;
    endfunction

    task automatic check_outputs();
        check("dout",       32'(bus.dout),       32'(m_hold));
        check("dout_valid", 32'(bus.dout_valid), 32'(m_vld));
        check("bit_cnt",    32'(bus.bit_cnt),    32'(m_bits.size()));
        check("overrun",    32'(bus.overrun),    32'(m_ovr));
    endtask

    // One clock: scoreboard a consume, advance the model with the inputs seen at the edge, compare.
    task automatic step();
        logic         old_vld;
        logic         complete;
        logic [W-1:0] word;
        if (bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
            else                   check("sb_word", 32'(bus.dout), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        old_vld  = m_vld;
        complete = 1'b0;
        word     = '0;
        if (bus.flush) begin
            m_bits.delete();
        end else if (bus.sin_valid) begin
            if (m_bits.size() == 0) m_dir = bus.msb_first;
            m_bits.push_back(bus.sin);
            if (m_bits.size() == W) begin
                word     = assemble(m_dir);
                complete = 1'b1;
                m_bits.delete();
            end
        end
        if (bus.clr_ovr) m_ovr = 1'b0;
        if (old_vld && bus.dout_ready) m_vld = 1'b0;
        if (complete) begin
            if (!old_vld || bus.dout_ready) begin
                m_hold = word;
                m_vld  = 1'b1;
                exp_q.push_back(word);
            end else begin
                m_ovr = 1'b1;
            end
        end
        #1;
        check_outputs();
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        bus.sin       = b;
        bus.sin_valid = 1'b1;
        step();
        bus.sin_valid = 1'b0;
    endtask

    task automatic send_word_msb(input logic [W-1:0] w);
        bus.msb_first = 1'b1;
        for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle();
        step();
    endtask

    task automatic reset_mid_cycle();
        #3;
        reset = 1'b1;
        #1;
        check("rst_dout",    32'(bus.dout),       32'd0);
        check("rst_valid",   32'(bus.dout_valid), 32'd0);
        check("rst_bit_cnt", 32'(bus.bit_cnt),    32'd0);
        check("rst_overrun", 32'(bus.overrun),    32'd0);
        model_clear();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset          = 1'b1;
        bus.sin        = 1'b0;
        bus.sin_valid  = 1'b0;
        bus.msb_first  = 1'b0;
        bus.flush      = 1'b0;
        bus.clr_ovr    = 1'b0;
        bus.dout_ready = 1'b0;
        model_clear();
        #12;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;

        // msb-first word 1011 with downstream ready: valid for exactly one cycle
        bus.dout_ready = 1'b1;
        send_word_msb(4'b1011);
        check("s1_dout",  32'(bus.dout),       32'hB);
        check("s1_valid", 32'(bus.dout_valid), 32'd1);
        check("s1_cnt",   32'(bus.bit_cnt),    32'd0);
        idle();
        check("s1_valid_drop", 32'(bus.dout_valid), 32'd0);

        // lsb-first 1,0,1,1 -> 1101, then same with msb_first toggled mid-word
        bus.msb_first = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check("s2_dout", 32'(bus.dout), 32'hD);
        idle();
        bus.msb_first = 1'b0;
        send_bit(1'b1); send_bit(1'b0);
        bus.msb_first = 1'b1;
        send_bit(1'b1); send_bit(1'b1);
        check("s2_toggle_dout", 32'(bus.dout), 32'hD);
        idle();

        // overrun: A held, 5 dropped; clr_ovr clears only the flag
        bus.dout_ready = 1'b0;
        send_word_msb(4'hA);
        send_word_msb(4'h5);
        check("s3_dout",  32'(bus.dout),       32'hA);
        check("s3_valid", 32'(bus.dout_valid), 32'd1);
        check("s3_ovr",   32'(bus.overrun),    32'd1);
        bus.clr_ovr = 1'b1;
        idle();
        bus.clr_ovr = 1'b0;
        check("s3_clr_ovr",   32'(bus.overrun),    32'd0);
        check("s3_clr_dout",  32'(bus.dout),       32'hA);
        check("s3_clr_valid", 32'(bus.dout_valid), 32'd1);

        // completion on the same edge as consuming the held word
        bus.msb_first = 1'b1;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus.dout_ready = 1'b1;
        send_bit(1'b0);
        bus.dout_ready = 1'b0;
        check("s4_dout",  32'(bus.dout),       32'h6);
        check("s4_valid", 32'(bus.dout_valid), 32'd1);
        check("s4_ovr",   32'(bus.overrun),    32'd0);

        // flush drops a partial word but leaves the held word alone
        send_bit(1'b1); send_bit(1'b1);
        bus.flush = 1'b1;
        bus.sin   = 1'b1;
        bus.sin_valid = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.sin_valid = 1'b0;
        check("s5_cnt",   32'(bus.bit_cnt),    32'd0);
        check("s5_dout",  32'(bus.dout),       32'h6);
        check("s5_valid", 32'(bus.dout_valid), 32'd1);
        bus.dout_ready = 1'b1;
        send_word_msb(4'b0110);
        check("s5_new_dout", 32'(bus.dout), 32'h6);
        check("s5_new_ovr",  32'(bus.overrun), 32'd0);
        idle();

        // asynchronous reset mid-word with a word held
        bus.dout_ready = 1'b0;
        send_word_msb(4'h9);
        send_bit(1'b1); send_bit(1'b0);
        reset_mid_cycle();
        send_word_msb(4'hC);
        check("s6_dout",  32'(bus.dout),       32'hC);
        check("s6_valid", 32'(bus.dout_valid), 32'd1);
        bus.dout_ready = 1'b1;
        idle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.sin        = 1'($urandom_range(0, 1));
            bus.sin_valid  = ($urandom_range(0, 3) != 0);
            bus.msb_first  = 1'($urandom_range(0, 1));
            bus.flush      = ($urandom_range(0, 15) == 0);
            bus.clr_ovr    = ($urandom_range(0, 7) == 0);
            bus.dout_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        bus.sin_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.clr_ovr   = 1'b0;

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sipo_rx4.md
SIPO_RX4 -- requirements
Module: sipo_rx4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the deserialized word width; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port sin, input, 1 bit: serial data bit.
REQ-005 The block SHALL have port sin_valid, input, 1 bit: sin is accepted on this rising edge.
REQ-006 The block SHALL have port msb_first, input, 1 bit: 1 = first received bit becomes dout[WIDTH-1]; 0 = first received bit becomes dout[0].
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous discard of any partial word.
REQ-008 The block SHALL have port clr_ovr, input, 1 bit: synchronous clear of overrun.
REQ-009 The block SHALL have port dout_ready, input, 1 bit: downstream accepts dout.
REQ-010 The block SHALL have port dout, output, WIDTH bits: last completed word.
REQ-011 The block SHALL have port dout_valid, output, 1 bit: dout holds an unconsumed word.
REQ-012 The block SHALL have port bit_cnt, output, ceil(log2(WIDTH+1)) bits: number of bits of the current partial word received so far.
REQ-013 The block SHALL have port overrun, output, 1 bit: sticky flag, a completed word was dropped.

Function
REQ-014 The block SHALL keep an internal shift register sh[WIDTH-1:0], a bit counter, a latched direction bit, and an output holding register driving dout.
REQ-015 The block SHALL latch msb_first into the direction bit only on an accepted bit while bit_cnt = 0; changes of msb_first mid-word SHALL NOT affect the current word.
REQ-016 With msb_first latched = 1, each accepted bit SHALL shift sh left and enter at sh[0].
REQ-017 With msb_first latched = 0, each accepted bit SHALL shift sh right and enter at sh[WIDTH-1].
REQ-018 Each accepted bit with bit_cnt < WIDTH-1 SHALL increment bit_cnt by 1.
REQ-019 An accepted bit with bit_cnt = WIDTH-1 SHALL complete the word: the fully shifted value is written to the holding register when permitted (REQ-021..023), and bit_cnt returns to 0 on the same edge.
REQ-020 Latency SHALL be one cycle: dout and dout_valid reflect the completed word on the edge that accepts its last bit.
REQ-021 Handshake: a word SHALL be consumed on any edge where dout_valid = 1 and dout_ready = 1; dout_valid then clears unless a new word completes on the same edge.
REQ-022 On completion with dout_valid = 0, or with dout_valid = 1 and dout_ready = 1 on the same edge, the new word SHALL be written and dout_valid SHALL be 1 after the edge.
REQ-023 On completion with dout_valid = 1 and dout_ready = 0, the new word SHALL be dropped, dout SHALL keep the old word, and overrun SHALL be set.
REQ-024 dout SHALL remain stable while dout_valid = 1 and no consume occurs.
REQ-025 flush = 1 SHALL clear bit_cnt and sh on the edge; flush SHALL take priority over sin_valid; the holding register, dout_valid, and overrun SHALL NOT be affected.
REQ-026 clr_ovr = 1 SHALL clear overrun; if an overrun event occurs on the same edge, overrun SHALL be 1 (set wins).
REQ-027 sin_valid = 0 SHALL leave sh and bit_cnt unchanged; idle gaps between bits of a word are unlimited.

Reset
REQ-028 While reset = 1, sh, dout, bit_cnt, dout_valid, overrun, and the direction bit SHALL be 0, asynchronously, independent of clk.
REQ-029 Reset deasserted mid-word SHALL leave no partial word; the next accepted bit is bit 0 of a new word.

Verification
REQ-030 The bench SHALL cover the following scenario: WIDTH=4, msb_first=1, bits 1,0,1,1 with dout_ready=1 -> dout=4'b1011, dout_valid=1 for exactly one cycle, bit_cnt back to 0.
REQ-031 The bench SHALL cover the following scenario: msb_first=0, bits 1,0,1,1 -> dout=4'b1101; toggling msb_first after the 2nd bit still gives 4'b1101.
REQ-032 The bench SHALL cover the following scenario: dout_ready=0, two words 4'hA then 4'h5 -> dout stays 4'hA, dout_valid=1, overrun=1; clr_ovr then clears overrun only.
REQ-033 The bench SHALL cover the following scenario: word complete on the same edge as a consume of the previous word -> dout updates to the new word, dout_valid stays 1, overrun=0.
REQ-034 The bench SHALL cover the following scenario: 2 bits sent, then flush, then 4 bits 0,1,1,0 (msb_first=1) -> dout=4'b0110; a valid word already held across the flush is unaffected.
REQ-035 The bench SHALL cover the following scenario: reset asserted between clk edges mid-word with dout_valid=1 -> all outputs 0 immediately; next 4 bits form a complete fresh word.
